// File: rtl/bp_cce_pkg.sv
// ============================================================================
// Module      : bp_cce_pkg
// Description : Shared types for the CCE config loader: loader FSM states,
//               mode-register encoding and width helpers.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package bp_cce_pkg;

    typedef enum logic [2:0] {
        S_RESET     = 3'd0,
        S_WRITE     = 3'd1,
        S_READ_REQ  = 3'd2,
        S_READ_RESP = 3'd3,
        S_MODE      = 3'd4,
        S_NEXT      = 3'd5,
        S_DONE      = 3'd6,
        S_ERROR     = 3'd7
    } cce_state_e;

    typedef enum logic [0:0] {
        e_cce_mode_uncached = 1'b0,
        e_cce_mode_normal   = 1'b1
    } cce_mode_e;

    function automatic int ceil_div(input int num, input int den);
        return (num + den - 1) / den;
    endfunction

    // Counter width that stays legal when only one value is ever needed.
    function automatic int min_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/bp_cce_cfg_beat_slicer.sv
// ============================================================================
// Module      : bp_cce_cfg_beat_slicer
// Description : Selects one config-link-wide beat of an instruction word,
//               zero-padding the final partial beat.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bp_cce_cfg_beat_slicer
    import bp_cce_pkg::*;
#(
    parameter int inst_width_p = 48,
    parameter int data_width_p = 32,
    localparam int beats_lp    = ceil_div(inst_width_p, data_width_p),
    localparam int beat_w_lp   = min_width(beats_lp)
) (
    input  logic [inst_width_p-1:0] inst_i,
    input  logic [beat_w_lp-1:0]    beat_i,
    output logic [data_width_p-1:0] data_o
);

    logic [beats_lp*data_width_p-1:0] padded;

    always_comb begin
        padded                     = '0;
        padded[inst_width_p-1:0]   = inst_i;
        data_o                     = padded[beat_i*data_width_p +: data_width_p];
    end

endmodule

`default_nettype wire

// File: rtl/bp_cce_multi_cfg_loader.sv
// ============================================================================
// Module      : bp_cce_multi_cfg_loader
// Description : Streams the boot ROM into each CCE's instruction RAM over the
//               config link, then switches each CCE to normal mode.
//               Optional readback verification: BP_CCE_CFG_READBACK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bp_cce_multi_cfg_loader
    import bp_cce_pkg::*;
#(
    parameter int num_cce_p             = 2,
    parameter int inst_width_p          = 48,
    parameter int inst_ram_els_p        = 256,
    parameter int cfg_link_addr_width_p = 16,
    parameter int cfg_link_data_width_p = 32,
    parameter int mode_reg_addr_p       = 'h0000,
    localparam int beats_lp             = ceil_div(inst_width_p, cfg_link_data_width_p),
    localparam int inst_addr_width_lp   = $clog2(inst_ram_els_p)
) (
    input  logic                                       clk_i,
    input  logic                                       reset_i,
    output logic                                       freeze_o,
    output logic                                       done_o,
    output logic                                       error_o,
    output logic [inst_addr_width_lp-1:0]              boot_rom_addr_o,
    input  logic [inst_width_p-1:0]                    boot_rom_data_i,
    output logic [cfg_link_addr_width_p-2:0]           config_addr_o,
    output logic [cfg_link_data_width_p-1:0]           config_data_o,
    output logic                                       config_w_o,
    output logic [num_cce_p-1:0]                       config_v_o,
    input  logic [num_cce_p-1:0]                       config_ready_i,
    input  logic [num_cce_p*cfg_link_data_width_p-1:0] config_data_i,
    input  logic [num_cce_p-1:0]                       config_v_i,
    output logic [num_cce_p-1:0]                       config_ready_o
);

    localparam int beat_w_lp = min_width(beats_lp);
    localparam int cce_w_lp  = min_width(num_cce_p);
    localparam int addr_w_lp = cfg_link_addr_width_p - 1;

    cce_state_e                     state_q, state_d;
    logic [cce_w_lp-1:0]            cce_q, cce_d;
    logic [inst_addr_width_lp-1:0]  entry_q, entry_d, entry_nxt;
    logic [beat_w_lp-1:0]           beat_q, beat_d, beat_nxt;
    logic [cfg_link_data_width_p-1:0] beat_data;
    logic [addr_w_lp-1:0]           data_addr;
    logic [num_cce_p-1:0]           cce_sel;
    logic                           last_beat, last_entry, req_xfer;

    bp_cce_cfg_beat_slicer #(
        .inst_width_p (inst_width_p),
        .data_width_p (cfg_link_data_width_p)
    ) u_beat_slicer (
        .inst_i (boot_rom_data_i),
        .beat_i (beat_q),
        .data_o (beat_data)
    );

    assign boot_rom_addr_o = entry_q;
    assign cce_sel         = num_cce_p'(1) << cce_q;
    assign data_addr       = addr_w_lp'(entry_q) * addr_w_lp'(beats_lp) + addr_w_lp'(beat_q);
    assign last_beat       = (beat_q == beat_w_lp'(beats_lp - 1));
    assign last_entry      = (entry_q == inst_addr_width_lp'(inst_ram_els_p - 1));
    // Valid comes only from state, so ready never reaches valid combinationally.
    assign req_xfer        = |(config_v_o & config_ready_i);

    // Entry-major, beat-minor walk that wraps to zero after the final beat.
    always_comb begin
        beat_nxt  = last_beat ? '0 : beat_q + 1'b1;
        entry_nxt = entry_q;
        if (last_beat) begin
            entry_nxt = last_entry ? '0 : entry_q + 1'b1;
        end
    end

`ifdef BP_CCE_CFG_READBACK_EN
    logic [cfg_link_data_width_p-1:0] rsp_data;
    assign rsp_data = config_data_i[cce_q*cfg_link_data_width_p +: cfg_link_data_width_p];
`else
    logic unused_rsp;
    assign unused_rsp = ^{config_data_i, config_v_i};
`endif

    always_comb begin
        state_d        = state_q;
        cce_d          = cce_q;
        entry_d        = entry_q;
        beat_d         = beat_q;
        config_v_o     = '0;
        config_w_o     = 1'b0;
        config_addr_o  = data_addr;
        config_data_o  = '0;
        config_ready_o = '0;
        freeze_o       = 1'b1;
        done_o         = 1'b0;
        error_o        = 1'b0;
        case (state_q)
            S_RESET: state_d = S_WRITE;
            S_WRITE: begin
                config_v_o    = cce_sel;
                config_w_o    = 1'b1;
                config_data_o = beat_data;
                if (req_xfer) begin
                    beat_d  = beat_nxt;
                    entry_d = entry_nxt;
                    if (last_beat && last_entry) begin
`ifdef BP_CCE_CFG_READBACK_EN
                        state_d = S_READ_REQ;
`else
                        state_d = S_MODE;
`endif
                    end
                end
            end
`ifdef BP_CCE_CFG_READBACK_EN
            S_READ_REQ: begin
                config_v_o = cce_sel;
                if (req_xfer) begin
                    state_d = S_READ_RESP;
                end
            end
            S_READ_RESP: begin
                config_ready_o = cce_sel;
                if (config_v_i[cce_q]) begin
                    if (rsp_data != beat_data) begin
                        state_d = S_ERROR;
                    end else begin
                        beat_d  = beat_nxt;
                        entry_d = entry_nxt;
                        state_d = (last_beat && last_entry) ? S_MODE : S_READ_REQ;
                    end
                end
            end
            S_ERROR: error_o = 1'b1;
`endif
            S_MODE: begin
                config_v_o    = cce_sel;
                config_w_o    = 1'b1;
                config_addr_o = addr_w_lp'(mode_reg_addr_p);
                config_data_o = cfg_link_data_width_p'(e_cce_mode_normal);
                if (req_xfer) begin
                    state_d = S_NEXT;
                end
            end
            S_NEXT: begin
                if (cce_q == cce_w_lp'(num_cce_p - 1)) begin
                    state_d = S_DONE;
                end else begin
                    cce_d   = cce_q + 1'b1;
                    state_d = S_WRITE;
                end
            end
            S_DONE: begin
                freeze_o = 1'b0;
                done_o   = 1'b1;
            end
            default: state_d = state_q;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= S_RESET;
            cce_q   <= '0;
            entry_q <= '0;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            cce_q   <= cce_d;
            entry_q <= entry_d;
            beat_q  <= beat_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_bp_cce_multi_cfg_loader.sv
// ============================================================================
// Module      : tb_bp_cce_multi_cfg_loader
// Description : Directed self-checking bench for the CCE config loader
//               (2 CCEs x 4 entries, 48-bit words over a 32-bit link).
//               Readback scenarios follow BP_CCE_CFG_READBACK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bp_cce_multi_cfg_loader;

    localparam int NCCE = 2;
    localparam int IW   = 48;
    localparam int ELS  = 4;
    localparam int AW   = 16;
    localparam int DW   = 32;

    typedef struct packed {
        logic [3:0]    cce;
        logic          w;
        logic [AW-2:0] addr;
        logic [DW-1:0] data;
    } xfer_t;

    logic                 clk = 1'b0;
    logic                 reset_i;
    logic                 freeze_o, done_o, error_o, config_w_o;
    logic [1:0]           boot_rom_addr_o;
    logic [IW-1:0]        boot_rom_data_i;
    logic [AW-2:0]        config_addr_o;
    logic [DW-1:0]        config_data_o;
    logic [NCCE-1:0]      config_v_o, config_ready_i, config_v_i, config_ready_o;
    logic [NCCE*DW-1:0]   config_data_i;

    logic [IW-1:0]        rom [ELS];
    logic [DW-1:0]        mem [NCCE][8];
    xfer_t                exp_q [$];
    int                   n_checks = 0;
    int                   n_errors = 0;

    always #5 clk = ~clk;

    assign boot_rom_data_i = rom[boot_rom_addr_o];

    bp_cce_multi_cfg_loader #(
        .num_cce_p             (NCCE),
        .inst_width_p          (IW),
        .inst_ram_els_p        (ELS),
        .cfg_link_addr_width_p (AW),
        .cfg_link_data_width_p (DW),
        .mode_reg_addr_p       ('h0000)
    ) u_dut (
        .clk_i           (clk),
        .reset_i         (reset_i),
        .freeze_o        (freeze_o),
        .done_o          (done_o),
        .error_o         (error_o),
        .boot_rom_addr_o (boot_rom_addr_o),
        .boot_rom_data_i (boot_rom_data_i),
        .config_addr_o   (config_addr_o),
        .config_data_o   (config_data_o),
        .config_w_o      (config_w_o),
        .config_v_o      (config_v_o),
        .config_ready_i  (config_ready_i),
        .config_data_i   (config_data_i),
        .config_v_i      (config_v_i),
        .config_ready_o  (config_ready_o)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
        end
    endtask

    // Hand-derived beats: beat 0 is the low 32 bits, beat 1 the top 16 zero-padded.
    function automatic logic [DW-1:0] exp_beat(input int e, input int b);
        if (b == 0) return 32'h1111_1111 * (e + 1);
        return {16'h0000, 16'hBE00 | 16'(e)};
    endfunction

    function automatic int vec_idx(input logic [NCCE-1:0] v);
        for (int i = 0; i < NCCE; i++) if (v[i]) return i;
        return 15;
    endfunction

    task automatic check_reset_vals(input string tag);
        check_eq({tag, "_freeze"}, freeze_o, 1);
        check_eq({tag, "_done"}, done_o, 0);
        check_eq({tag, "_error"}, error_o, 0);
        check_eq({tag, "_v"}, config_v_o, 0);
        check_eq({tag, "_rdy"}, config_ready_o, 0);
        check_eq({tag, "_romaddr"}, boot_rom_addr_o, 0);
    endtask

    task automatic build_expected(input int err_cce, input int err_addr);
        exp_q.delete();
        for (int c = 0; c < NCCE; c++) begin
            for (int a = 0; a < 8; a++) exp_q.push_back({4'(c), 1'b1, 15'(a), exp_beat(a / 2, a % 2)});
`ifdef BP_CCE_CFG_READBACK_EN
            for (int a = 0; a < 8; a++) begin
                exp_q.push_back({4'(c), 1'b0, 15'(a), 32'h0});
                if (c == err_cce && a == err_addr) return;
            end
`endif
            exp_q.push_back({4'(c), 1'b1, 15'h0, 32'h1});
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_i = 1'b1;
        config_v_i = '0;
        @(negedge clk);
        check_reset_vals("rst");
        reset_i = 1'b0;
    endtask

    task automatic run_seq(input bit stall_en, input bit corrupt, input bit rst_mid);
        xfer_t         cur, held, ex;
        int            idx = 0, stall = 0, cyc = 0, pcce = 0;
        bit            pending = 0, did_rst = 0, finished = 0;
        logic [DW-1:0] pdata = '0;
        held = '0;
        build_expected(corrupt ? 1 : -1, 5);
        while (!finished && cyc < 600) begin
            @(negedge clk);
            cyc++;
            config_v_i    = '0;
            config_data_i = '0;
            if (pending) begin
                config_v_i[pcce]              = 1'b1;
                config_data_i[pcce*DW +: DW]  = pdata;
                if (config_ready_o[pcce]) pending = 0;
            end
            config_ready_i = '1;
            if (done_o || error_o) begin
                finished = 1;
            end else if (config_v_o != '0) begin
                cur = {4'(vec_idx(config_v_o)), config_w_o, config_addr_o, config_data_o};
                if (rst_mid && !did_rst && cur.cce == 1 && cur.w && cur.addr == 2) begin
                    reset_i = 1'b1;
                    #1 check_reset_vals("mid_rst");
                    @(negedge clk);
                    check_reset_vals("mid_rst_hold");
                    reset_i = 1'b0;
                    config_v_i = '0;
                    did_rst = 1;
                    idx = 0;
                    pending = 0;
                    continue;
                end
                if (stall_en && cur.cce == 0 && cur.w && cur.addr == 3 && stall < 3) begin
                    if (stall == 0) held = cur;
                    else check_eq("stall_hold", cur, held);
                    config_ready_i[0] = 1'b0;
                    stall++;
                end else begin
                    if (stall_en && cur.cce == 0 && cur.w && cur.addr == 3) begin
                        check_eq("stall_release", cur, held);
                        check_eq("stall_cycles", stall, 3);
                    end
                    check_eq("onehot_v", $onehot(config_v_o), 1);
                    check_eq("freeze_busy", freeze_o, 1);
`ifndef BP_CCE_CFG_READBACK_EN
                    check_eq("err_low", error_o, 0);
`endif
                    if (idx < exp_q.size()) begin
                        ex = exp_q[idx];
                        if (!ex.w) begin
                            cur.data = '0;
                            ex.data  = '0;
                        end
                        check_eq($sformatf("xfer%0d", idx), cur, ex);
                    end else begin
                        check_eq("extra_xfer", idx, exp_q.size());
                    end
                    idx++;
                    if (cur.w) mem[cur.cce[0]][cur.addr[2:0]] = config_data_o;
                    else begin
                        pending = 1;
                        pcce    = int'(cur.cce);
                        pdata   = mem[cur.cce[0]][cur.addr[2:0]] ^
                                  ((corrupt && cur.cce == 1 && cur.addr == 5) ? 32'h1 : 32'h0);
                    end
                end
            end
        end
        if (!finished) check_eq("timeout", 0, 1);
        check_eq("rst_seen", did_rst, rst_mid);
        check_eq("xfer_count", idx, exp_q.size());
        check_eq("done_end", done_o, !corrupt);
        check_eq("error_end", error_o, corrupt);
        check_eq("freeze_end", freeze_o, corrupt);
        repeat (4) begin
            @(negedge clk);
            check_eq("quiet_v", config_v_o, 0);
            check_eq("hold_done", done_o, !corrupt);
        end
    endtask

    initial begin
        reset_i        = 1'b1;
        config_ready_i = '0;
        config_v_i     = '0;
        config_data_i  = '0;
        for (int e = 0; e < ELS; e++) rom[e] = {16'hBE00 | 16'(e), 32'h1111_1111 * (e + 1)};
        for (int c = 0; c < NCCE; c++) for (int a = 0; a < 8; a++) mem[c][a] = '0;
        #1 check_reset_vals("por");
        @(negedge clk);
        reset_i = 1'b0;
        run_seq(0, 0, 0);
        do_reset();
        run_seq(1, 0, 0);
        do_reset();
        run_seq(0, 0, 1);
`ifdef BP_CCE_CFG_READBACK_EN
        do_reset();
        run_seq(0, 1, 0);
`endif
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
